// File: rtl/axis_level_trigger.sv
// axis_level_trigger: AXI-Stream pass-through with level/edge trigger detection,
// hysteresis arming, holdoff and a wrapping trigger counter.
module axis_level_trigger #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ADC_DATA_WIDTH   = 14,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        trg_enable,
    input  logic                        trg_chan,
    input  logic                        trg_edge,
    input  logic [ADC_DATA_WIDTH-1:0]   trg_level,
    input  logic [ADC_DATA_WIDTH-1:0]   trg_hyst,
    input  logic [CNTR_WIDTH-1:0]       holdoff,
    output logic                        trg_flag,
    output logic [CNTR_WIDTH-1:0]       sts_data,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid
);
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        HOLDOFF  = 2'd2
    } state_t;

    // Two guard bits so level +/- hyst can never wrap at the range extremes.
    localparam int CW = ADC_DATA_WIDTH + 2;

    state_t                        state_q, state_d;
    logic [CNTR_WIDTH-1:0]         cnt_q, cnt_d;
    logic [CNTR_WIDTH-1:0]         sts_q, sts_d;
    logic                          flag_q, flag_d;
    logic [AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                          tvalid_q, tvalid_d;
    logic [ADC_DATA_WIDTH-1:0]     raw;
    logic signed [CW-1:0]          sample, level, low, high;
    logic                          arm, fire;

    assign s_axis_tready = 1'b1;
    assign trg_flag      = flag_q;
    assign sts_data      = sts_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

    always_comb begin
        raw    = trg_chan ? s_axis_tdata[16+ADC_DATA_WIDTH-1:16] : s_axis_tdata[ADC_DATA_WIDTH-1:0];
        sample = {{2{raw[ADC_DATA_WIDTH-1]}}, raw};
        level  = {{2{trg_level[ADC_DATA_WIDTH-1]}}, trg_level};
        low    = level - {2'b00, trg_hyst};
        high   = level + {2'b00, trg_hyst};
        arm    = trg_edge ? (sample > high) : (sample < low);
        fire   = trg_edge ? (sample <= level) : (sample >= level);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sts_d    = sts_q;
        flag_d   = 1'b0;
        tdata_d  = s_axis_tdata;
        tvalid_d = s_axis_tvalid;
        if (!trg_enable) begin
            state_d = DISARMED;
            cnt_d   = '0;
        end else if (s_axis_tvalid) begin
            case (state_q)
                DISARMED: state_d = arm ? ARMED : DISARMED;
                ARMED: begin
                    if (fire) begin
                        flag_d  = 1'b1;
                        sts_d   = sts_q + CNTR_WIDTH'(1);
                        cnt_d   = holdoff;
                        state_d = (holdoff == '0) ? DISARMED : HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    cnt_d   = (cnt_q <= CNTR_WIDTH'(1)) ? '0 : cnt_q - CNTR_WIDTH'(1);
                    state_d = (cnt_q <= CNTR_WIDTH'(1)) ? DISARMED : HOLDOFF;
                end
                default: state_d = DISARMED;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= DISARMED;
            cnt_q    <= '0;
            sts_q    <= '0;
            flag_q   <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sts_q    <= sts_d;
            flag_q   <= flag_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
        end
    end
endmodule
